// File: rtl/axi_10g_ethernet_0_tcp_hdr_gen.sv
// axi_10g_ethernet_0_tcp_hdr_gen: TCP pseudo-header + header checksum and sequence numbering per payload segment
module axi_10g_ethernet_0_tcp_hdr_gen #(
  parameter int TCP_DATA_LENGTH = 1456
) (
  input  logic        s_aclk,
  input  logic        s_aresetn,
  output logic        csum_rd_en,
  input  logic        csum_empty,
  input  logic [15:0] csum_dout,
  input  logic [31:0] src_ip,
  input  logic [31:0] dst_ip,
  input  logic [15:0] src_port,
  input  logic [15:0] dst_port,
  input  logic [31:0] ack_num,
  input  logic [7:0]  tcp_flags,
  input  logic [15:0] window,
  input  logic        seq_load,
  input  logic [31:0] seq_init,
  output logic        hdr_tvalid,
  input  logic        hdr_tready,
  output logic [31:0] hdr_seq,
  output logic [15:0] hdr_checksum
);
  typedef enum logic [2:0] {IDLE, WAIT, SUM, FOLD, OUT} state_t;
  state_t state, next;
  logic [3:0]  cnt;
  logic [19:0] acc, fold;
  logic [31:0] seq_cnt, src_ip_r, dst_ip_r, ack_r;
  logic [15:0] src_port_r, dst_port_r, window_r, pay_r, word;
  logic [7:0]  flags_r;
  logic [15:0] words [16];
  logic        hs;
  assign hdr_tvalid = state == OUT;
  assign hs = hdr_tvalid & hdr_tready;
  assign csum_rd_en = s_aresetn & (state == IDLE) & ~csum_empty;
  assign fold = {4'd0, acc[15:0]} + {16'd0, acc[19:16]};
  // Summation schedule: one 16-bit word per SUM cycle; checksum and urgent pointer are zero so they are omitted
  always_comb begin
    words = '{src_ip_r[31:16], src_ip_r[15:0], dst_ip_r[31:16], dst_ip_r[15:0], 16'h0006,
              16'(20 + TCP_DATA_LENGTH), src_port_r, dst_port_r, hdr_seq[31:16], hdr_seq[15:0],
              ack_r[31:16], ack_r[15:0], {4'd5, 4'd0, flags_r}, window_r, pay_r, 16'd0};
    word = words[cnt];
  end
  // Next-state logic; cnt restarts on every state change so it times SUM and FOLD
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = csum_empty ? IDLE : WAIT;
      WAIT:    next = SUM;
      SUM:     next = (cnt == 4'd14) ? FOLD : SUM;
      FOLD:    next = (cnt == 4'd1) ? OUT : FOLD;
      OUT:     next = hdr_tready ? IDLE : OUT;
      default: next = IDLE;
    endcase
  end
  // State, sequence counter, segment latches and the checksum datapath
  always_ff @(posedge s_aclk) begin
    if (!s_aresetn) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      acc          <= 20'd0;
      seq_cnt      <= 32'd0;
      hdr_seq      <= 32'd0;
      hdr_checksum <= 16'd0;
    end else begin
      state <= next;
      cnt   <= (next != state) ? 4'd0 : cnt + 4'd1;
      if (seq_load) seq_cnt <= seq_init;
      else if (hs) seq_cnt <= seq_cnt + 32'(TCP_DATA_LENGTH);
      if (csum_rd_en) begin
        hdr_seq    <= seq_cnt;
        src_ip_r   <= src_ip;
        dst_ip_r   <= dst_ip;
        src_port_r <= src_port;
        dst_port_r <= dst_port;
        ack_r      <= ack_num;
        flags_r    <= tcp_flags;
        window_r   <= window;
      end
      if (state == WAIT) begin
        pay_r <= csum_dout;
        acc   <= 20'd0;
      end
      if (state == SUM) acc <= acc + {4'd0, word};
      if (state == FOLD) acc <= fold;
      if (state == FOLD && cnt == 4'd1) hdr_checksum <= ~fold[15:0];
    end
  end
endmodule

// File: tb/tb_axi_10g_ethernet_0_tcp_hdr_gen.sv
// tb_axi_10g_ethernet_0_tcp_hdr_gen: randomized self-checking bench with a behavioural checksum/sequence model
module tb_axi_10g_ethernet_0_tcp_hdr_gen;
  localparam int L = 1456;
  logic s_aclk = 1'b0, s_aresetn = 1'b0;
  logic csum_rd_en, csum_empty, seq_load = 1'b0, hdr_tvalid, hdr_tready = 1'b0;
  logic [15:0] csum_dout = 16'd0, src_port = 16'd0, dst_port = 16'd0, window = 16'd0, hdr_checksum;
  logic [31:0] src_ip = 32'd0, dst_ip = 32'd0, ack_num = 32'd0, seq_init = 32'd0, hdr_seq;
  logic [7:0]  tcp_flags = 8'd0;
  logic [15:0] mem [256];
  logic [7:0]  wr_ptr = 8'd0, rd_ptr = 8'd0;
  logic [31:0] model_seq = 32'd0;
  int cyc = 0, n_cmp = 0, n_err = 0;

  axi_10g_ethernet_0_tcp_hdr_gen #(.TCP_DATA_LENGTH(L)) dut (
    .s_aclk(s_aclk), .s_aresetn(s_aresetn), .csum_rd_en(csum_rd_en), .csum_empty(csum_empty),
    .csum_dout(csum_dout), .src_ip(src_ip), .dst_ip(dst_ip), .src_port(src_port), .dst_port(dst_port),
    .ack_num(ack_num), .tcp_flags(tcp_flags), .window(window), .seq_load(seq_load), .seq_init(seq_init),
    .hdr_tvalid(hdr_tvalid), .hdr_tready(hdr_tready), .hdr_seq(hdr_seq), .hdr_checksum(hdr_checksum)
  );

  always #5 s_aclk = ~s_aclk;
  always @(posedge s_aclk) cyc <= cyc + 1;

  // payload-checksum FIFO: data appears the cycle after the read strobe
  assign csum_empty = (wr_ptr == rd_ptr);
  always @(posedge s_aclk) if (csum_rd_en) begin
    csum_dout <= mem[rd_ptr];
    rd_ptr <= rd_ptr + 8'd1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [15:0] model_cs(input logic [31:0] sip, dip, sq, ak,
                                           input logic [15:0] sp, dp, win, pay, input logic [7:0] fl);
    logic [31:0] s;
    s = 32'(sip[31:16]) + 32'(sip[15:0]) + 32'(dip[31:16]) + 32'(dip[15:0]) + 32'd6 + 32'(20 + L)
      + 32'(sp) + 32'(dp) + 32'(sq[31:16]) + 32'(sq[15:0]) + 32'(ak[31:16]) + 32'(ak[15:0])
      + 32'h5000 + 32'(fl) + 32'(win) + 32'(pay);
    while (s[31:16] != 16'd0) s = 32'(s[15:0]) + 32'(s[31:16]);
    return ~s[15:0];
  endfunction

  task automatic tick;
    @(posedge s_aclk);
    #1;
  endtask

  task automatic push(input logic [15:0] v);
    mem[wr_ptr] = v;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic set_hdr(input bit rnd);
    src_ip    = rnd ? $urandom : 32'd0;
    dst_ip    = rnd ? $urandom : 32'd0;
    src_port  = rnd ? 16'($urandom) : 16'd0;
    dst_port  = rnd ? 16'($urandom) : 16'd0;
    ack_num   = rnd ? $urandom : 32'd0;
    tcp_flags = rnd ? 8'($urandom) : 8'd0;
    window    = rnd ? 16'($urandom) : 16'd0;
  endtask

  // drives one segment up to the first hdr_tvalid cycle; lat = -1 when a bounded wait expires
  task automatic start_seg(input bit do_push, input logic [15:0] pay, input bit rnd,
                           output int lat, output int t_rd, output logic [15:0] e_cs, output logic [31:0] e_sq);
    set_hdr(rnd);
    e_sq = model_seq;
    e_cs = model_cs(src_ip, dst_ip, model_seq, ack_num, src_port, dst_port, window, pay, tcp_flags);
    if (do_push) push(pay);
    #1;
    lat = -1;
    t_rd = -1;
    for (int i = 0; i < 40; i++) begin
      if (csum_rd_en) begin
        t_rd = cyc;
        break;
      end
      tick;
    end
    if (t_rd >= 0) begin
      tick;
      set_hdr(1);
      seq_init = $urandom;
      for (int i = 0; i < 40; i++) begin
        if (hdr_tvalid) begin
          lat = cyc - t_rd;
          break;
        end
        tick;
      end
    end
  endtask

  task automatic handshake(input bit ld, input logic [31:0] v);
    seq_load = ld;
    seq_init = v;
    hdr_tready = 1'b1;
    tick;
    model_seq = ld ? v : model_seq + 32'(L);
    hdr_tready = 1'b0;
    seq_load = 1'b0;
  endtask

  task automatic test_reset;
    s_aresetn = 1'b0;
    repeat (3) tick;
    n_cmp += 4;
    if (hdr_tvalid !== 1'b0) begin n_err++; $display("FAIL reset_tvalid: got %b want 0", hdr_tvalid); end
    if (hdr_seq !== 32'd0) begin n_err++; $display("FAIL reset_seq: got %h want 0", hdr_seq); end
    if (hdr_checksum !== 16'd0) begin n_err++; $display("FAIL reset_csum: got %h want 0", hdr_checksum); end
    if (csum_rd_en !== 1'b0) begin n_err++; $display("FAIL reset_rd_en: got %b want 0", csum_rd_en); end
    s_aresetn = 1'b1;
    model_seq = 32'd0;
    tick;
  endtask

  task automatic test_basic;
    int lat, t;
    logic [15:0] ecs;
    logic [31:0] esq;
    start_seg(1, 16'h0000, 0, lat, t, ecs, esq);
    n_cmp += 5;
    if (lat != 19) begin n_err++; $display("FAIL basic_latency: got %0d want 19", lat); end
    if (hdr_checksum !== 16'hAA35) begin n_err++; $display("FAIL basic_csum_const: got %h want aa35", hdr_checksum); end
    if (hdr_checksum !== ecs) begin n_err++; $display("FAIL basic_csum_model: got %h want %h", hdr_checksum, ecs); end
    if (hdr_seq !== 32'd0) begin n_err++; $display("FAIL basic_seq: got %h want 0", hdr_seq); end
    if (hdr_seq !== esq) begin n_err++; $display("FAIL basic_seq_model: got %h want %h", hdr_seq, esq); end
    handshake(1, 32'd0);
    n_cmp++;
    if (hdr_tvalid !== 1'b0) begin n_err++; $display("FAIL basic_deassert: got %b want 0", hdr_tvalid); end
  endtask

  task automatic test_neg_zero;
    int lat, t;
    logic [15:0] ecs;
    logic [31:0] esq;
    start_seg(1, 16'hFFFF, 0, lat, t, ecs, esq);
    n_cmp += 3;
    if (lat != 19) begin n_err++; $display("FAIL negzero_latency: got %0d want 19", lat); end
    if (hdr_checksum !== 16'hAA35) begin n_err++; $display("FAIL negzero_csum: got %h want aa35", hdr_checksum); end
    if (hdr_seq !== 32'd0) begin n_err++; $display("FAIL negzero_seq: got %h want 0", hdr_seq); end
    handshake(0, 32'd0);
  endtask

  task automatic test_wrap;
    int lat, t;
    logic [15:0] ecs;
    logic [31:0] esq;
    logic [31:0] want [2];
    want[0] = 32'hFFFFFD00;
    want[1] = 32'h000002B0;
    seq_load = 1'b1;
    seq_init = 32'hFFFFFD00;
    tick;
    seq_load = 1'b0;
    model_seq = 32'hFFFFFD00;
    for (int i = 0; i < 2; i++) begin
      start_seg(1, 16'($urandom), 1, lat, t, ecs, esq);
      n_cmp += 3;
      if (hdr_seq !== want[i]) begin n_err++; $display("FAIL wrap_seq%0d: got %h want %h", i, hdr_seq, want[i]); end
      if (hdr_seq !== esq) begin n_err++; $display("FAIL wrap_seq_model%0d: got %h want %h", i, hdr_seq, esq); end
      if (hdr_checksum !== ecs) begin n_err++; $display("FAIL wrap_csum%0d: got %h want %h", i, hdr_checksum, ecs); end
      handshake(0, 32'd0);
    end
  endtask

  task automatic test_collision;
    int lat, t;
    logic [15:0] ecs;
    logic [31:0] esq;
    start_seg(1, 16'($urandom), 1, lat, t, ecs, esq);
    handshake(1, 32'h00001000);
    start_seg(1, 16'($urandom), 1, lat, t, ecs, esq);
    n_cmp += 2;
    if (hdr_seq !== 32'h00001000) begin n_err++; $display("FAIL collision_seq: got %h want 00001000", hdr_seq); end
    if (hdr_checksum !== ecs) begin n_err++; $display("FAIL collision_csum: got %h want %h", hdr_checksum, ecs); end
    handshake(0, 32'd0);
  endtask

  task automatic test_backpressure;
    int lat, t;
    logic [15:0] ecs, p2;
    logic [31:0] esq;
    start_seg(1, 16'($urandom), 1, lat, t, ecs, esq);
    p2 = 16'($urandom);
    push(p2);
    for (int i = 0; i < 10; i++) begin
      #1;
      n_cmp += 5;
      if (hdr_tvalid !== 1'b1) begin n_err++; $display("FAIL bp_tvalid%0d: got %b want 1", i, hdr_tvalid); end
      if (hdr_seq !== esq) begin n_err++; $display("FAIL bp_seq%0d: got %h want %h", i, hdr_seq, esq); end
      if (hdr_checksum !== ecs) begin n_err++; $display("FAIL bp_csum%0d: got %h want %h", i, hdr_checksum, ecs); end
      if (csum_rd_en !== 1'b0) begin n_err++; $display("FAIL bp_rd_en%0d: got %b want 0", i, csum_rd_en); end
      if (wr_ptr - rd_ptr !== 8'd1) begin n_err++; $display("FAIL bp_fifo_level%0d: got %0d want 1", i, wr_ptr - rd_ptr); end
      tick;
    end
    handshake(0, 32'd0);
    start_seg(0, p2, 1, lat, t, ecs, esq);
    n_cmp += 3;
    if (lat != 19) begin n_err++; $display("FAIL bp_next_latency: got %0d want 19", lat); end
    if (hdr_seq !== esq) begin n_err++; $display("FAIL bp_next_seq: got %h want %h", hdr_seq, esq); end
    if (hdr_checksum !== ecs) begin n_err++; $display("FAIL bp_next_csum: got %h want %h", hdr_checksum, ecs); end
    handshake(0, 32'd0);
  endtask

  task automatic test_back_to_back;
    int lat, t, t_prev;
    logic [15:0] ecs;
    logic [15:0] pays [3];
    logic [31:0] esq;
    for (int i = 0; i < 3; i++) begin
      pays[i] = 16'($urandom);
      push(pays[i]);
    end
    t_prev = 0;
    for (int i = 0; i < 3; i++) begin
      start_seg(0, pays[i], 1, lat, t, ecs, esq);
      n_cmp += 3;
      if (lat != 19) begin n_err++; $display("FAIL b2b_latency%0d: got %0d want 19", i, lat); end
      if (hdr_seq !== esq) begin n_err++; $display("FAIL b2b_seq%0d: got %h want %h", i, hdr_seq, esq); end
      if (hdr_checksum !== ecs) begin n_err++; $display("FAIL b2b_csum%0d: got %h want %h", i, hdr_checksum, ecs); end
      if (i > 0) begin
        n_cmp++;
        if (t - t_prev != 20) begin n_err++; $display("FAIL b2b_period%0d: got %0d want 20", i, t - t_prev); end
      end
      t_prev = t;
      handshake(0, 32'd0);
      n_cmp++;
      if (hdr_tvalid !== 1'b0) begin n_err++; $display("FAIL b2b_deassert%0d: got %b want 0", i, hdr_tvalid); end
    end
  endtask

  task automatic test_abort;
    int lat, t;
    bit seen;
    logic [15:0] ecs, pb;
    logic [31:0] esq;
    set_hdr(1);
    push(16'($urandom));
    #1;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (csum_rd_en) seen = 1;
      else tick;
    end
    n_cmp++;
    if (!seen) begin n_err++; $display("FAIL abort_first_pop: got no read strobe want one"); end
    repeat (5) tick;
    pb = 16'($urandom);
    push(pb);
    s_aresetn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      n_cmp += 2;
      if (hdr_tvalid !== 1'b0) begin n_err++; $display("FAIL abort_tvalid%0d: got %b want 0", i, hdr_tvalid); end
      if (csum_rd_en !== 1'b0) begin n_err++; $display("FAIL abort_rd_en%0d: got %b want 0", i, csum_rd_en); end
    end
    s_aresetn = 1'b1;
    model_seq = 32'd0;
    start_seg(0, pb, 1, lat, t, ecs, esq);
    n_cmp += 3;
    if (lat != 19) begin n_err++; $display("FAIL abort_next_latency: got %0d want 19", lat); end
    if (hdr_seq !== 32'd0) begin n_err++; $display("FAIL abort_next_seq: got %h want 0", hdr_seq); end
    if (hdr_checksum !== ecs) begin n_err++; $display("FAIL abort_next_csum: got %h want %h", hdr_checksum, ecs); end
    handshake(0, 32'd0);
  endtask

  task automatic test_random;
    int lat, t, stall;
    logic [15:0] ecs;
    logic [31:0] esq;
    for (int i = 0; i < 8; i++) begin
      start_seg(1, 16'($urandom), 1, lat, t, ecs, esq);
      stall = $urandom_range(0, 3);
      repeat (stall) tick;
      n_cmp += 3;
      if (lat != 19) begin n_err++; $display("FAIL rand_latency%0d: got %0d want 19", i, lat); end
      if (hdr_seq !== esq) begin n_err++; $display("FAIL rand_seq%0d: got %h want %h", i, hdr_seq, esq); end
      if (hdr_checksum !== ecs) begin n_err++; $display("FAIL rand_csum%0d: got %h want %h", i, hdr_checksum, ecs); end
      handshake(0, 32'd0);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_neg_zero;
    test_wrap;
    test_collision;
    test_backpressure;
    test_back_to_back;
    test_abort;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/axi_10g_ethernet_0_tcp_hdr_gen.md
AXI_10G_ETHERNET_0_TCP_HDR_GEN -- requirements
Module: axi_10g_ethernet_0_tcp_hdr_gen

Interface
REQ-001 SHALL have parameter TCP_DATA_LENGTH, default 1456, meaning the payload bytes per segment.
REQ-002 SHALL have port s_aclk, input, 1 bit, the single clock.
REQ-003 SHALL have port s_aresetn, input, 1 bit; reset is synchronous and active-low.
REQ-004 SHALL have port csum_rd_en, output, 1 bit, the read strobe to the payload-checksum FIFO.
REQ-005 SHALL have port csum_empty, input, 1 bit, the payload-checksum FIFO empty flag.
REQ-006 SHALL have port csum_dout, input, 16 bits, the FIFO data, valid the cycle after csum_rd_en.
REQ-007 SHALL have ports src_ip and dst_ip, each input, 32 bits, the IPv4 addresses.
REQ-008 SHALL have ports src_port and dst_port, each input, 16 bits, the TCP ports.
REQ-009 SHALL have port ack_num, input, 32 bits, the acknowledgement number.
REQ-010 SHALL have port tcp_flags, input, 8 bits, the TCP flags.
REQ-011 SHALL have port window, input, 16 bits, the advertised window.
REQ-012 SHALL have port seq_load, input, 1 bit, which loads the sequence counter from seq_init.
REQ-013 SHALL have port seq_init, input, 32 bits, the initial sequence number.
REQ-014 SHALL have ports hdr_tvalid (output, 1 bit) and hdr_tready (input, 1 bit), the header-result handshake.
REQ-015 SHALL have ports hdr_seq (output, 32 bits) and hdr_checksum (output, 16 bits), the segment sequence number and the final TCP checksum.

Function
REQ-016 Each csum_dout entry SHALL be treated as the folded, uninverted ones-complement sum of one TCP_DATA_LENGTH payload.
REQ-017 The FSM SHALL have these states and transitions:
- IDLE -> WAIT when csum_empty=0.
- WAIT -> SUM.
- SUM -> FOLD after 15 cycles.
- FOLD -> OUT after 2 cycles.
- OUT -> IDLE when hdr_tvalid and hdr_tready are both high.
REQ-018 csum_rd_en SHALL be combinational, (state==IDLE) & ~csum_empty; this guarantees exactly one pop per segment and no pop outside IDLE.
REQ-019 On the csum_rd_en cycle, the block SHALL latch all header inputs and the sequence counter; input changes after that cycle do not affect the segment in flight.
REQ-020 In WAIT, the block SHALL capture csum_dout.
REQ-021 In SUM, the block SHALL add one 16-bit word per cycle into a 20-bit accumulator cleared at WAIT, in this order:
- src_ip[31:16], src_ip[15:0], dst_ip[31:16], dst_ip[15:0];
- 16'h0006;
- 20+TCP_DATA_LENGTH (16-bit);
- src_port, dst_port;
- seq[31:16], seq[15:0];
- ack[31:16], ack[15:0];
- {4'd5,4'd0,tcp_flags}, window;
- the captured payload sum.
REQ-022 The checksum and urgent-pointer fields SHALL contribute zero to the sum.
REQ-023 FOLD SHALL perform acc = acc[15:0] + acc[19:16] twice; hdr_checksum SHALL be ~acc[15:0].
REQ-024 A computed 0x0000 SHALL be output unchanged, with no substitution.
REQ-025 Latency: with csum_rd_en high at cycle T, hdr_tvalid SHALL first go high at cycle T+19.
REQ-026 While hdr_tvalid=1 and hdr_tready=0, hdr_seq and hdr_checksum SHALL be held stable and no FIFO read SHALL occur.
REQ-027 hdr_tvalid SHALL deassert in the cycle after the handshake.
REQ-028 On the OUT handshake, the sequence counter SHALL advance by TCP_DATA_LENGTH, modulo 2^32 (wrap-around).
REQ-029 seq_load SHALL be accepted in any state and SHALL affect only segments not yet latched.
REQ-030 If seq_load coincides with the OUT handshake, seq_init SHALL win.
REQ-031 Back-to-back segments SHALL have one IDLE cycle between the handshake and the next csum_rd_en, giving a minimum period of 20 cycles.

Reset
REQ-032 When s_aresetn=0 at a rising edge, the block SHALL:
- set state=IDLE, sequence counter=0, accumulator=0;
- set hdr_tvalid=0, hdr_seq=0, hdr_checksum=0;
- keep csum_rd_en=0 throughout reset.
REQ-033 Reset mid-operation SHALL abort the segment and discard a FIFO entry already popped; no output handshake occurs for it.
REQ-034 After reset is released, operation SHALL resume from IDLE on the next edge.

Verification
REQ-035 Basic: all header inputs 0, seq 0, payload sum 0x0000 -> hdr_checksum=0xAA35, hdr_seq=0x00000000, hdr_tvalid first high 19 cycles after csum_rd_en.
REQ-036 Negative zero: same as REQ-035 with payload sum 0xFFFF -> the carry folds and hdr_checksum=0xAA35.
REQ-037 Wrap: seq_init=0xFFFFFD00 loaded, two segments handshaked -> hdr_seq=0xFFFFFD00, then hdr_seq=0x000002B0.
REQ-038 Backpressure: hdr_tready low for 10 cycles with the FIFO non-empty -> outputs stable, csum_rd_en=0 throughout, one pop per handshake.
REQ-039 Collision: seq_load with seq_init=0x1000 in the handshake cycle -> next segment hdr_seq=0x00001000.
REQ-040 Abort: s_aresetn low during SUM -> hdr_tvalid stays 0, the next segment uses seq=0, and the checksum is correct for the next FIFO entry.
